apb_arb_mux: RTL
================

Name: apb_arb_mux

Overview:
- Parametrised N-master to 1-slave APB4 multiplexer; next-generation replacement for the fixed round-robin APB mux.
- Adds selectable arbitration mode, full-width PSTRB and 3-bit PPROT, and a registered request capture so the slave sees stable signals.
- Adds a wait-state timeout that terminates hung slave transfers with PSLVERR.
- Sits between the APB requester fabric and a single APB4 target (peripheral bridge).

Parameters:
- NUM_APB_MASTERS, 4, number of requesting masters (1..32).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width; must be 8, 16 or 32.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before forced error; 0 disables the timeout.

Ports:
- PCLK  in  1  clock, all logic rising-edge.
- PRESET  in  1  synchronous active-high reset.
- PSEL_s  in  N  per-master select.
- PADDR_s  in  N x AW  per-master address (unpacked array).
- PWRITE_s  in  N  per-master write.
- PWDATA_s  in  N x DW  per-master write data.
- PENABLE_s  in  N  per-master enable.
- PSTRB_s  in  N x DW/8  per-master byte strobes.
- PPROT_s  in  N x 3  per-master protection.
- PRDATA_s  out  N x DW  read data to masters.
- PREADY_s  out  N  ready to masters.
- PSLVERR_s  out  N  error to masters.
- PSEL_m / PENABLE_m / PWRITE_m  out  1  slave controls.
- PADDR_m  out  AW  slave address.
- PWDATA_m  out  DW  slave write data.
- PSTRB_m  out  DW/8  slave byte strobes.
- PPROT_m  out  3  slave protection.
- PRDATA_m  in  DW  slave read data.
- PREADY_m  in  1  slave ready.
- PSLVERR_m  in  1  slave error.
- gnt_idx_o  out  $clog2(N) (min 1)  index of current owner; valid while busy_o.
- busy_o  out  1  transfer in progress (state != IDLE).
- timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - State IDLE, RR pointer 0, timeout counter 0.
  - Capture registers, PSEL_m, PENABLE_m, PADDR_m, PWDATA_m, PSTRB_m, PPROT_m, PWRITE_m all 0.
  - PREADY_s, PSLVERR_s, PRDATA_s, busy_o, timeout_o, gnt_idx_o all 0.
  - Reset mid-transfer drops the slave transfer immediately; the owning master never receives PREADY.
- Requests:
  - req[i] = PSEL_s[i]. A master holds PSEL with PREADY_s low (standard wait state) until it is served.
- Arbitration (IDLE only, combinational on req):
  - RR: search from the pointer upward with wrap; pointer <= winner+1 mod N at grant.
  - Fixed priority: lowest set index wins; pointer unused.
- FSM IDLE -> SETUP -> ACCESS -> IDLE:
  - IDLE:
    - If any req: latch the winner's index and its PADDR/PWRITE/PWDATA/PSTRB/PPROT into the capture registers; go to SETUP.
    - Slave outputs are 0.
  - SETUP:
    - PSEL_m=1, PENABLE_m=0, slave fields driven from the capture registers.
    - Always go to ACCESS next cycle.
  - ACCESS:
    - PSEL_m=1, PENABLE_m=1.
    - If PREADY_m: PREADY_s[g]=1, PSLVERR_s[g]=PSLVERR_m, PRDATA_s[g]=PRDATA_m, all combinational in that cycle; go to IDLE.
    - Else if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1: PREADY_s[g]=1, PSLVERR_s[g]=1, PRDATA_s[g]=0, timeout_o=1; go to IDLE. PSEL_m drops next cycle.
    - PREADY_m takes precedence over timeout in the same cycle.
- Timeout counter:
  - Clears on entry to ACCESS; increments each ACCESS cycle without PREADY_m.
  - Width $clog2(TIMEOUT_CYCLES+1); saturating.
- Non-owner masters: PREADY_s=0, PSLVERR_s=0, PRDATA_s=0 at all times.
- Latency: minimum 3 cycles from PSEL_s to PREADY_s (IDLE, SETUP, ACCESS with zero-wait slave). One IDLE cycle between consecutive transfers.
- Owner drops PSEL_s mid-transfer (protocol violation): the slave transfer still completes; the response is driven but ignored.
- N=1: arbitration degenerates to a pass-through with capture; the pointer stays 0.
- Slave-side address and data are stable through SETUP and ACCESS even if the master changes its inputs.

Decomposition:
- Package apb_arb_mux_pkg:
  - state_t enum (IDLE, SETUP, ACCESS).
  - arb_mode_e (ARB_RR=0, ARB_FIXED=1).
  - APB_PROT_WIDTH=3.
- Sub-module apb_arbiter:
  - Parametrised N and ARB_MODE; inputs req, advance, PCLK, PRESET.
  - Outputs one-hot gnt and gnt_idx; owns the RR pointer.

Test Plan:
- N=4, RR, masters 0 and 2 request continuously, zero-wait slave -> grants alternate 0,2,0,2; each transfer 3 cycles; PADDR_m matches the owner's address.
- Fixed priority, masters 1 and 3 request -> master 1 is served repeatedly while it holds PSEL; master 3 is served only after master 1 deasserts.
- Master 0 write, PADDR 0x1000, PWDATA 0xDEADBEEF, PSTRB 0b0101, PPROT 0b010, slave inserts 2 wait states -> slave fields stable for 4 cycles; PREADY_s[0] high for exactly 1 cycle.
- TIMEOUT_CYCLES=8, slave never ready -> at the 8th ACCESS cycle PSLVERR_s[g]=1, PREADY_s[g]=1, PRDATA_s=0, timeout_o pulses once; FSM returns to IDLE.
- Slave asserts PREADY_m in the same cycle the timeout expires -> normal completion; PSLVERR_s follows PSLVERR_m and timeout_o stays 0.
- PRESET asserted during ACCESS -> next cycle PSEL_m=0, busy_o=0, pointer 0; no PREADY_s is issued.

Source files
------------

// File: rtl/apb_arb_mux_pkg.sv
// apb_arb_mux_pkg: shared types and constants for the arbitrating APB mux
package apb_arb_mux_pkg;
    localparam int APB_PROT_WIDTH = 3;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;
endpackage

// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin or fixed-priority request arbiter with one-hot and index grant
module apb_arbiter
    import apb_arb_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int ARB_MODE = 0,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] base;
    logic [IW-1:0] off;
    logic [N-1:0]  rot;
    logic [IW:0]   sum;
    // rotate requests so the search always starts at bit 0, then map the offset back
    always_comb begin
        base = (ARB_MODE == int'(ARB_FIXED)) ? '0 : ptr;
        rot = N'({req, req} >> base);
        off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) off = IW'(k);
        sum = {1'b0, base} + {1'b0, off};
        gnt_idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
        gnt = (req != '0) ? (N'(1) << gnt_idx) : '0;
    end
    always_ff @(posedge PCLK)
        if (PRESET || ARB_MODE == int'(ARB_FIXED) || N == 1)
            ptr <= '0;
        else if (advance && req != '0)
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
endmodule

// File: rtl/apb_arb_mux.sv
// apb_arb_mux: N-master to 1-slave APB4 mux with arbitration, request capture and wait-state timeout
module apb_arb_mux
    import apb_arb_mux_pkg::*;
#(
    parameter int NUM_APB_MASTERS = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int N = NUM_APB_MASTERS,
    localparam int AW = APB_ADDR_WIDTH,
    localparam int DW = APB_DATA_WIDTH,
    localparam int SW = APB_DATA_WIDTH / 8,
    localparam int PW = APB_PROT_WIDTH,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic [N-1:0]  PSEL_s,
    input  logic [AW-1:0] PADDR_s [N],
    input  logic [N-1:0]  PWRITE_s,
    input  logic [DW-1:0] PWDATA_s [N],
    input  logic [N-1:0]  PENABLE_s,
    input  logic [SW-1:0] PSTRB_s [N],
    input  logic [PW-1:0] PPROT_s [N],
    output logic [DW-1:0] PRDATA_s [N],
    output logic [N-1:0]  PREADY_s,
    output logic [N-1:0]  PSLVERR_s,
    output logic          PSEL_m,
    output logic          PENABLE_m,
    output logic          PWRITE_m,
    output logic [AW-1:0] PADDR_m,
    output logic [DW-1:0] PWDATA_m,
    output logic [SW-1:0] PSTRB_m,
    output logic [PW-1:0] PPROT_m,
    input  logic [DW-1:0] PRDATA_m,
    input  logic          PREADY_m,
    input  logic          PSLVERR_m,
    output logic [IW-1:0] gnt_idx_o,
    output logic          busy_o,
    output logic          timeout_o
);
    state_t        state, state_n;
    logic [N-1:0]  arb_gnt;
    logic [IW-1:0] arb_idx;
    logic [IW-1:0] own;
    logic          cap_write;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_strb;
    logic [PW-1:0] cap_prot;
    logic [CW-1:0] cnt;
    logic          tmo, done, act;
    // requests come from PSEL alone, so PENABLE_s carries no information here
    logic          unused_ok;
    assign unused_ok = ^PENABLE_s;

    apb_arbiter #(.N(N), .ARB_MODE(ARB_MODE)) u_arb (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req     (PSEL_s),
        .advance (state == IDLE),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        tmo = state == ACCESS && !PREADY_m && TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
        done = state == ACCESS && (PREADY_m || tmo);
        state_n = (state == IDLE) ? ((|arb_gnt) ? SETUP : IDLE) :
                  (state == SETUP) ? ACCESS : (done ? IDLE : ACCESS);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            own       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            cap_prot  <= '0;
            cnt       <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |arb_gnt) begin
                own       <= arb_idx;
                cap_write <= PWRITE_s[arb_idx];
                cap_addr  <= PADDR_s[arb_idx];
                cap_wdata <= PWDATA_s[arb_idx];
                cap_strb  <= PSTRB_s[arb_idx];
                cap_prot  <= PPROT_s[arb_idx];
            end
            cnt <= (state == SETUP) ? '0 :
                   (state == ACCESS && !PREADY_m && cnt != '1) ? cnt + CW'(1) : cnt;
        end
    end

    always_comb begin
        act = state != IDLE;
        PSEL_m = act;
        PENABLE_m = state == ACCESS;
        PWRITE_m = act ? cap_write : 1'b0;
        PADDR_m = act ? cap_addr : '0;
        PWDATA_m = act ? cap_wdata : '0;
        PSTRB_m = act ? cap_strb : '0;
        PPROT_m = act ? cap_prot : '0;
        for (int i = 0; i < N; i++) begin
            PREADY_s[i] = done && own == IW'(i);
            PSLVERR_s[i] = PREADY_s[i] && (tmo || PSLVERR_m);
            PRDATA_s[i] = (PREADY_s[i] && !tmo) ? PRDATA_m : '0;
        end
        busy_o = act;
        timeout_o = tmo;
        gnt_idx_o = own;
    end
endmodule
